mux_word_serializer: RTL and testbench



---
 rtl/mux_word_serializer.sv | 106 ++++++++++
 tb/tb_mux_word_serializer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_word_serializer.sv
// Serializes a held word through an external 16:1 bit-select mux, one select
// position per accepted output beat, with valid/ready/last framing.
module mux_word_serializer #(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_ZERO  = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] SEL_ONE   = {{(SEL_W-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] SEL_TOP   = SEL_W'(WIDTH - 1);
  localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_TOP : SEL_ZERO;
  localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? SEL_ZERO : SEL_TOP;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] mux_in_r, mux_in_s;
  logic [SEL_W-1:0] mux_sel_r, mux_sel_s;
  logic             shift_s;
  logic             last_s;

  assign shift_s = (state_r == SHIFT);
  assign last_s  = shift_s && (mux_sel_r == SEL_END);

  // in_ready combinationally follows out_ready on the last beat so back-to-back
  // words need no bubble; flush/rst deassert it because no word is taken then.
  assign in_ready  = !rst && !flush && (!shift_s || (last_s && out_ready));
  assign out_valid = shift_s;
  assign busy      = shift_s;
  assign out_last  = last_s;
  assign out_bit   = mux_out;
  assign mux_in    = mux_in_r;
  assign mux_sel   = mux_sel_r;

  // Next-state, held word and select stepping.
  always_comb begin
    state_s   = state_r;
    mux_in_s  = mux_in_r;
    mux_sel_s = mux_sel_r;
    if (flush) begin
      state_s   = IDLE;
      mux_sel_s = SEL_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_s   = SHIFT;
            mux_in_s  = in_data;
            mux_sel_s = SEL_START;
          end else begin
            state_s = IDLE;
          end
        end
        SHIFT: begin
          if (!out_ready) begin
            state_s = SHIFT;
          end else if (!last_s) begin
            mux_sel_s = MSB_FIRST ? (mux_sel_r - SEL_ONE) : (mux_sel_r + SEL_ONE);
          end else if (in_valid) begin
            mux_in_s  = in_data;
            mux_sel_s = SEL_START;
          end else begin
            state_s = IDLE;
          end
        end
        default: begin
          state_s   = IDLE;
          mux_sel_s = SEL_ZERO;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      mux_in_r  <= {WIDTH{1'b0}};
      mux_sel_r <= SEL_ZERO;
    end else begin
      state_r   <= state_s;
      mux_in_r  <= mux_in_s;
      mux_sel_r <= mux_sel_s;
    end
  end

endmodule

// File: tb/tb_mux_word_serializer.sv
// Drives an LSB-first and an MSB-first serializer with shared stimulus and checks
// both against a word/beat-index reference model plus captured serial streams.
module tb_mux_word_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid, flush, out_ready;

  logic        l_in_ready, l_mux_out, l_out_bit, l_out_valid, l_out_last, l_busy;
  logic [15:0] l_mux_in;
  logic [3:0]  l_mux_sel;
  logic        m_in_ready, m_mux_out, m_out_bit, m_out_valid, m_out_last, m_busy;
  logic [15:0] m_mux_in;
  logic [3:0]  m_mux_sel;

  int checks = 0;
  int errors = 0;

  // reference model: word in flight and number of beats already delivered
  logic [15:0] ref_word;
  int          ref_idx;
  bit          ref_active;
  bit          ref_at_end;
  bit          accepted;

  bit q_l[$];
  bit q_m[$];
  int lasts_l, lasts_m;

  always #5 clk = ~clk;

  assign l_mux_out = l_mux_in[l_mux_sel];
  assign m_mux_out = m_mux_in[m_mux_sel];

  mux_word_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_in_ready),
    .flush(flush), .mux_in(l_mux_in), .mux_sel(l_mux_sel), .mux_out(l_mux_out),
    .out_bit(l_out_bit), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_last(l_out_last), .busy(l_busy)
  );

  mux_word_serializer #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
    .flush(flush), .mux_in(m_mux_in), .mux_sel(m_mux_sel), .mux_out(m_mux_out),
    .out_bit(m_out_bit), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_last(m_out_last), .busy(m_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  // One clock: check outputs at negedge, advance the model, return at posedge+1.
  task automatic step();
    logic        exp_rdy;
    logic [31:0] sel_l, sel_m;
    @(negedge clk);
    if (!rst) begin
      exp_rdy = !flush && (!ref_active || (ref_idx == 15 && out_ready));
      sel_l   = ref_active ? 32'(ref_idx) : (ref_at_end ? 32'd15 : 32'd0);
      sel_m   = ref_active ? 32'(15 - ref_idx) : 32'd0;
      chk("in_ready_l", 32'(l_in_ready), 32'(exp_rdy));
      chk("in_ready_m", 32'(m_in_ready), 32'(exp_rdy));
      chk("out_valid_l", 32'(l_out_valid), 32'(ref_active));
      chk("out_valid_m", 32'(m_out_valid), 32'(ref_active));
      chk("busy_l", 32'(l_busy), 32'(ref_active));
      chk("busy_m", 32'(m_busy), 32'(ref_active));
      chk("mux_in_l", 32'(l_mux_in), 32'(ref_word));
      chk("mux_in_m", 32'(m_mux_in), 32'(ref_word));
      chk("mux_sel_l", 32'(l_mux_sel), sel_l);
      chk("mux_sel_m", 32'(m_mux_sel), sel_m);
      chk("out_last_l", 32'(l_out_last), 32'(ref_active && ref_idx == 15));
      chk("out_last_m", 32'(m_out_last), 32'(ref_active && ref_idx == 15));
      if (ref_active) begin
        chk("out_bit_l", 32'(l_out_bit), 32'(ref_word[ref_idx]));
        chk("out_bit_m", 32'(m_out_bit), 32'(ref_word[15-ref_idx]));
      end
      if (!flush && l_out_valid && out_ready) begin
        q_l.push_back(l_out_bit);
        if (l_out_last) lasts_l++;
      end
      if (!flush && m_out_valid && out_ready) begin
        q_m.push_back(m_out_bit);
        if (m_out_last) lasts_m++;
      end
    end
    accepted = 1'b0;
    if (rst) begin
      ref_word = 16'h0000; ref_active = 1'b0; ref_at_end = 1'b0;
    end else if (flush) begin
      ref_active = 1'b0; ref_at_end = 1'b0;
    end else if (ref_active && out_ready) begin
      if (ref_idx == 15) begin
        if (in_valid) begin
          ref_word = in_data; ref_idx = 0; accepted = 1'b1;
        end else begin
          ref_active = 1'b0; ref_at_end = 1'b1;
        end
      end else begin
        ref_idx++;
      end
    end else if (!ref_active && in_valid) begin
      ref_word = in_data; ref_idx = 0; ref_active = 1'b1; accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n = 0;
    while (ref_active && n < max_cyc) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_accept(input string tag, input int max_cyc);
    int n = 0;
    do begin
      step();
      n++;
    end while (!accepted && n < max_cyc);
    chk({tag, "_accept_timeout"}, 32'(accepted), 32'd1);
  endtask

  task automatic chk_stream(input string tag, input int n, input logic [31:0] exp_l,
                            input logic [31:0] exp_m, input int exp_lasts);
    logic [31:0] v_l = 32'd0;
    logic [31:0] v_m = 32'd0;
    for (int i = 0; i < q_l.size() && i < 32; i++) v_l[i] = q_l[i];
    for (int i = 0; i < q_m.size() && i < 32; i++) v_m[i] = q_m[i];
    chk({tag, "_len_l"}, 32'(q_l.size()), 32'(n));
    chk({tag, "_len_m"}, 32'(q_m.size()), 32'(n));
    chk({tag, "_bits_l"}, v_l, exp_l);
    chk({tag, "_bits_m"}, v_m, exp_m);
    chk({tag, "_lasts_l"}, 32'(lasts_l), 32'(exp_lasts));
    chk({tag, "_lasts_m"}, 32'(lasts_m), 32'(exp_lasts));
    q_l.delete(); q_m.delete();
    lasts_l = 0; lasts_m = 0;
  endtask

  initial begin
    ref_word = 16'h0000; ref_idx = 0; ref_active = 1'b0; ref_at_end = 1'b0;
    lasts_l = 0; lasts_m = 0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
    step(); step();
    rst = 1'b0;
    repeat (5) step();

    // single set bit, no backpressure
    out_ready = 1'b1; in_data = 16'h0001; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 16'($urandom);
    drain("w0001", 40);
    step();
    chk_stream("w0001", 16, 32'h0000_0001, 32'(rev16(16'h0001)), 1);

    // stalls with out_ready pattern 1,0,0 repeating
    in_data = 16'hA5C3; in_valid = 1'b1;
    step();
    in_valid = 1'b0; in_data = 16'h5A3C;
    for (int c = 0; c < 100 && ref_active; c++) begin
      out_ready = (c % 3 == 0);
      step();
    end
    chk("wA5C3_timeout", 32'(ref_active), 32'd0);
    out_ready = 1'b1;
    step();
    chk_stream("wA5C3", 16, 32'h0000_A5C3, 32'(rev16(16'hA5C3)), 1);

    // back-to-back words, in_valid held
    in_valid = 1'b1; in_data = 16'hFFFF;
    wait_accept("b2b_first", 5);
    in_data = 16'h0000;
    wait_accept("b2b_second", 40);
    in_valid = 1'b0; in_data = 16'h1234;
    drain("b2b", 40);
    chk_stream("b2b", 32, 32'h0000_FFFF, 32'h0000_FFFF, 2);

    // flush after five beats, competing with a new word
    in_data = 16'h00F0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    flush = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk_stream("flush", 5, 32'(16'h00F0 & 16'h001F), 32'(rev16(16'h00F0) & 16'h001F), 0);

    // next word completes normally; MSB-first instance gives bits at beats 0 and 14
    in_data = 16'h8002; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain("w8002", 40);
    chk_stream("w8002", 16, 32'h0000_8002, 32'h0000_4001, 1);

    // randomized traffic with occasional flush and reset
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drain("random", 40);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
